// File: rtl/wb_initiator.sv
// Single-outstanding Wishbone classic-cycle initiator.
// Turns one valid/ready command into one Wishbone read or write cycle, then
// holds the slave's data (or a timeout error) on the response interface
// until the consumer takes it.
module wb_initiator #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 8,
  parameter int TIMEOUT    = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmdValid,
  output logic                  cmdReady,
  input  logic                  cmdWe,
  input  logic [ADDR_WIDTH-1:0] cmdAdr,
  input  logic [DATA_WIDTH-1:0] cmdDat,
  output logic                  rspValid,
  input  logic                  rspReady,
  output logic [DATA_WIDTH-1:0] rspDat,
  output logic                  rspErr,
  output logic                  wbCycO,
  output logic                  wbStbO,
  output logic                  wbWeO,
  output logic [ADDR_WIDTH-1:0] wbAdrO,
  output logic [DATA_WIDTH-1:0] wbDatO,
  input  logic [DATA_WIDTH-1:0] wbDatI,
  input  logic                  wbAckI
);

  typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

  // Last wait-count value before the cycle is abandoned; unused when TIMEOUT is 0.
  localparam logic [15:0] TO_LAST = 16'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  state_t                state, stateNxt;
  logic [15:0]           cnt, cntNxt;
  logic                  cycNxt, stbNxt, weNxt, rspValidNxt, rspErrNxt;
  logic [ADDR_WIDTH-1:0] adrNxt;
  logic [DATA_WIDTH-1:0] datNxt, rspDatNxt;

  assign cmdReady = (state == IDLE);

  // State and all registered outputs; reset drops the bus cycle at once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      cnt      <= '0;
      wbCycO   <= 1'b0;
      wbStbO   <= 1'b0;
      wbWeO    <= 1'b0;
      wbAdrO   <= '0;
      wbDatO   <= '0;
      rspValid <= 1'b0;
      rspDat   <= '0;
      rspErr   <= 1'b0;
    end else begin
      state    <= stateNxt;
      cnt      <= cntNxt;
      wbCycO   <= cycNxt;
      wbStbO   <= stbNxt;
      wbWeO    <= weNxt;
      wbAdrO   <= adrNxt;
      wbDatO   <= datNxt;
      rspValid <= rspValidNxt;
      rspDat   <= rspDatNxt;
      rspErr   <= rspErrNxt;
    end
  end

  // Next state and next register values; everything holds unless changed here.
  always_comb begin
    stateNxt    = state;
    cntNxt      = cnt;
    cycNxt      = wbCycO;
    stbNxt      = wbStbO;
    weNxt       = wbWeO;
    adrNxt      = wbAdrO;
    datNxt      = wbDatO;
    rspValidNxt = rspValid;
    rspDatNxt   = rspDat;
    rspErrNxt   = rspErr;
    case (state)
      IDLE: begin
        if (cmdValid) begin
          weNxt    = cmdWe;
          adrNxt   = cmdAdr;
          datNxt   = cmdDat;
          cycNxt   = 1'b1;
          stbNxt   = 1'b1;
          cntNxt   = '0;
          stateNxt = BUS;
        end
      end
      BUS: begin
        // Ack takes priority over a timeout landing on the same edge.
        if (wbAckI) begin
          cycNxt      = 1'b0;
          stbNxt      = 1'b0;
          rspDatNxt   = wbDatI;
          rspErrNxt   = 1'b0;
          rspValidNxt = 1'b1;
          stateNxt    = RESP;
        end else if (TIMEOUT != 0 && cnt == TO_LAST) begin
          cycNxt      = 1'b0;
          stbNxt      = 1'b0;
          rspDatNxt   = '0;
          rspErrNxt   = 1'b1;
          rspValidNxt = 1'b1;
          stateNxt    = RESP;
        end else begin
          cntNxt = cnt + 16'd1;
        end
      end
      RESP: begin
        if (rspReady) begin
          rspValidNxt = 1'b0;
          stateNxt    = IDLE;
        end
      end
      default: stateNxt = IDLE;
    endcase
  end

endmodule
